// File: rtl/instr_mem_loader_if.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_if
//
// Purpose: groups the byte-stream handshake, the instruction-memory write port
// and the boot status lines of the program loader into a single bundle.
//
// Signals:
//   in_valid   stream -> loader   byte on in_data is valid
//   in_data    stream -> loader   stream byte
//   in_ready   loader -> stream   loader accepts a byte this cycle
//   mem_we     loader -> memory   one-cycle write strobe
//   mem_addr   loader -> memory   byte address of the write (multiple of 4)
//   mem_wdata  loader -> memory   instruction word
//   cpu_reset  loader -> CPU      CPU held in reset until the load completes
//   done       loader -> system   load finished successfully (sticky)
//   error      loader -> system   header word count too large (sticky)
//
// Modports:
//   master  the loader itself
//   slave   the environment (byte source, memory, CPU, supervisor)
// -----------------------------------------------------------------------------
interface instr_mem_loader_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  cpu_reset;
  logic                  done;
  logic                  error;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output cpu_reset,
    output done,
    output error
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  cpu_reset,
    input  done,
    input  error
  );

endinterface

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//
// Purpose: boot-time program loader in front of the CPU instruction memory.
// It receives a byte stream made of a 16-bit little-endian word-count header
// followed by little-endian 32-bit instructions, assembles each word and
// writes it to instruction memory at byte addresses 0, 4, 8, ... while the
// CPU is held in reset. After the last write has landed, the CPU reset is
// released so execution begins at PC 0 with the whole program in place.
// A header larger than MAX_WORDS is rejected: no writes happen, the CPU
// stays in reset and error is raised until the next reset.
//
// Parameters:
//   MAX_WORDS   largest accepted word count
//   ADDR_WIDTH  width of mem_addr
//
// Ports:
//   clock   sole clock, all state changes on the rising edge
//   reset   synchronous, active-high reset
//   bus     instr_mem_loader_if.master (stream in, memory write out, status)
// -----------------------------------------------------------------------------
module instr_mem_loader #(
  parameter int MAX_WORDS  = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                clock,
  input  logic                reset,
  instr_mem_loader_if.master  bus
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    HDR0   = 3'd0,
    HDR1   = 3'd1,
    LOAD   = 3'd2,
    FINISH = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  // Word limit widened to the index width so the comparison is unsigned and
  // a header of 0xFFFF is handled without wrap.
  localparam logic [16:0] MAX_WORDS_W = 17'(MAX_WORDS);

  state_t state_r;
  state_t state_nxt_s;

  // Header and progress tracking
  logic [7:0]  count_lo_r;      // low header byte, captured in HDR0
  logic [15:0] count_r;         // total number of words to load
  logic [16:0] index_r;         // index of the word being collected
  logic [1:0]  byte_idx_r;      // position of the next byte inside the word
  logic [23:0] partial_r;       // bytes b0..b2 of the word being collected

  // Registered outputs
  logic                  mem_we_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [31:0]           mem_wdata_r;
  logic                  cpu_reset_r;
  logic                  done_r;
  logic                  error_r;

  // Combinational helpers
  logic        in_ready_s;
  logic        accept_s;
  logic [15:0] hdr_count_s;
  logic        hdr_too_big_s;
  logic        last_word_s;
  logic        word_load_s;

  // ---------------------------------------------------------------------------
  // Handshake and decode helpers
  // ---------------------------------------------------------------------------

  // Readiness depends only on the state and reset, never on in_valid, so the
  // byte source may present data combinationally against it.
  always_comb begin
    in_ready_s = 1'b0;
    if (reset) begin
      in_ready_s = 1'b0;
    end else begin
      case (state_r)
        HDR0, HDR1, LOAD: in_ready_s = 1'b1;
        default:          in_ready_s = 1'b0;
      endcase
    end
  end

  // Transfer qualifier and header / word-boundary decode.
  always_comb begin
    accept_s      = bus.in_valid & in_ready_s;
    // Header is little-endian: the byte arriving in HDR1 is the high byte.
    hdr_count_s   = {bus.in_data, count_lo_r};
    hdr_too_big_s = ({1'b0, hdr_count_s} > MAX_WORDS_W);
    // The word being assembled is the final one when index+1 reaches count.
    last_word_s   = ((index_r + 17'd1) == {1'b0, count_r});
    // A complete word is formed on the edge that accepts its fourth byte.
    word_load_s   = accept_s && (state_r == LOAD) && (byte_idx_r == 2'd3);
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      HDR0: begin
        if (accept_s) begin
          state_nxt_s = HDR1;
        end else begin
          state_nxt_s = HDR0;
        end
      end
      HDR1: begin
        if (accept_s) begin
          if (hdr_count_s == 16'd0) begin
            // Empty program: nothing to write, go straight to release.
            state_nxt_s = FINISH;
          end else if (hdr_too_big_s) begin
            state_nxt_s = ERROR;
          end else begin
            state_nxt_s = LOAD;
          end
        end else begin
          state_nxt_s = HDR1;
        end
      end
      LOAD: begin
        if (word_load_s && last_word_s) begin
          state_nxt_s = FINISH;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      // FINISH lasts one cycle so that the last write strobe lands while the
      // CPU is still held in reset.
      FINISH:  state_nxt_s = DONE;
      DONE:    state_nxt_s = DONE;
      ERROR:   state_nxt_s = ERROR;
      default: state_nxt_s = HDR0;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= HDR0;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------

  // Header capture, word assembly, index tracking and memory write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_lo_r  <= 8'd0;
      count_r     <= 16'd0;
      index_r     <= 17'd0;
      byte_idx_r  <= 2'd0;
      partial_r   <= 24'd0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r <= 32'd0;
    end else begin
      // Strobe is high only in the cycle after the fourth byte is accepted.
      mem_we_r <= word_load_s;

      if (accept_s && (state_r == HDR0)) begin
        count_lo_r <= bus.in_data;
      end

      if (accept_s && (state_r == HDR1)) begin
        count_r    <= hdr_count_s;
        index_r    <= 17'd0;
        byte_idx_r <= 2'd0;
        partial_r  <= 24'd0;
      end

      if (accept_s && (state_r == LOAD)) begin
        if (byte_idx_r == 2'd3) begin
          // First byte is the LSB, so the arriving byte forms bits 31:24.
          mem_wdata_r <= {bus.in_data, partial_r};
          mem_addr_r  <= ADDR_WIDTH'({index_r, 2'b00});
          index_r     <= index_r + 17'd1;
          byte_idx_r  <= 2'd0;
        end else begin
          case (byte_idx_r)
            2'd0:    partial_r[7:0]   <= bus.in_data;
            2'd1:    partial_r[15:8]  <= bus.in_data;
            2'd2:    partial_r[23:16] <= bus.in_data;
            default: partial_r        <= partial_r;
          endcase
          byte_idx_r <= byte_idx_r + 2'd1;
        end
      end
    end
  end

  // Boot status: derived from the upcoming state so each flag changes on the
  // same edge as the state transition that causes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_reset_r <= 1'b1;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      cpu_reset_r <= (state_nxt_s != DONE);
      done_r      <= (state_nxt_s == DONE);
      error_r     <= (state_nxt_s == ERROR);
    end
  end

  // ---------------------------------------------------------------------------
  // Output drive
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = in_ready_s;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.cpu_reset = cpu_reset_r;
  assign bus.done      = done_r;
  assign bus.error     = error_r;

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Boot-time program loader placed directly upstream of `risc_v_cpu`'s instruction memory. It accepts a byte stream (16-bit word-count header followed by little-endian 32-bit instructions), assembles the words, and writes them into instruction memory at byte addresses 0, 4, 8, … while holding the CPU in reset. Once the last word is written it releases the CPU reset, so execution starts at PC 0 with the full program in place.

## Interface
Parameters:
- `MAX_WORDS`, 256: largest accepted word count; larger headers raise `error`.
- `ADDR_WIDTH`, 32: width of `mem_addr`.

Ports:
- `clock`  input  1  sole clock; all state changes on rising edge.
- `reset`  input  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `in_valid`  input  1  byte on `in_data` is valid.
- `in_data`  input  8  stream byte.
- `in_ready`  output  1  loader accepts a byte this cycle.
- `mem_we`  output  1  one-cycle instruction-memory write strobe.
- `mem_addr`  output  ADDR_WIDTH  byte address of the write; always a multiple of 4.
- `mem_wdata`  output  32  instruction word.
- `cpu_reset`  output  1  drives the CPU `reset`; high until load completes.
- `done`  output  1  load finished successfully (sticky).
- `error`  output  1  header exceeded `MAX_WORDS` (sticky).

## Operation
- Handshake: byte transfers on a rising edge where `in_valid && in_ready`. `in_data` may change freely when not transferring; `in_valid` may drop at any time without loss.
- States: HDR0, HDR1, LOAD, FINISH, DONE, ERROR.
- HDR0: accept low count byte -> HDR1.
- HDR1: accept high count byte; count = {hi, lo}. Count 0 -> FINISH with no write. Count > `MAX_WORDS` -> ERROR. Otherwise -> LOAD, word index 0, byte index 0.
- LOAD: bytes 0..3 form word = {b3, b2, b1, b0} (first byte is LSB). On the edge accepting b3: `mem_we`<=1, `mem_wdata`<=word, `mem_addr`<=4*index, index++, byte index<=0. If that was word count-1, go to FINISH; otherwise stay in LOAD.
- FINISH: one cycle, `in_ready`=0, which allows the last write to land. At the next edge go to DONE.
- DONE: `cpu_reset`=0, `done`=1, `in_ready`=0. Further input is ignored. Stays here until `reset`.
- ERROR: `error`=1, `cpu_reset`=1, `in_ready`=0, no writes. Stays here until `reset`.
- `in_ready` = 1 in HDR0, HDR1, LOAD; 0 elsewhere and 0 while `reset` is high.
- Widths: index counter is 17 bits, so count 0xFFFF never wraps. `mem_addr` = index<<2, zero-extended to ADDR_WIDTH.

## Timing
- Reset values: state HDR0, `in_ready` 0 (during reset), `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `cpu_reset` 1, `done` 0, `error` 0. All counters and the partial-word register are cleared.
- Outputs `mem_we`, `mem_addr`, `mem_wdata`, `cpu_reset`, `done`, `error` are registered.
- `mem_we` is high for exactly one cycle, in the cycle after the edge that accepted b3. `mem_addr` and `mem_wdata` hold their values until the next write.
- Full-rate streaming (one byte per cycle) is sustained in LOAD. The write of word k overlaps with the collection of word k+1.
- Final byte accepted at edge E: `mem_we`=1 during [E, E+1) in FINISH. At edge E+1: `mem_we`=0, `cpu_reset`=0, `done`=1.
- Header count 0: HDR1 accepted at edge E; FINISH during [E, E+1); DONE at E+1.
- Reset mid-operation (any state): return to HDR0 at that edge. Any partial word is discarded, `cpu_reset` goes back to 1, and `done`/`error` clear. Memory already written is not modified.
- `in_valid` low mid-word: the byte index holds and no write is issued.

## Test plan
- Fibonacci program load: header 0x0006, then 6 words starting with 0x00100310 sent as bytes 10 03 10 00 … -> six `mem_we` pulses at addresses 0, 4, 8, 12, 16, 20 with the exact words. `cpu_reset` falls 2 cycles after the last byte. The CPU then runs and shows R7 = 1, 1, 2, 3, 5 at PC 8 on successive loop iterations.
- Gapped stream: the same 6-word program with `in_valid` deasserted for 3 cycles between every byte -> identical writes, addresses and data; no extra `mem_we` pulses.
- Header 0x0000 -> no `mem_we` pulse; `done`=1 and `cpu_reset`=0 exactly 2 edges after the second header byte.
- Header `MAX_WORDS`+1 (0x0101) -> `error`=1, `in_ready`=0, no writes, `cpu_reset` stays 1 for 20+ cycles of further `in_valid`.
- Reset asserted after 2 bytes of word 1 (word 0 already written) -> state returns to HDR0 and `cpu_reset`=1. A fresh header 0x0001 plus word 0xDEADBEEF then yields a single write to address 0 with 0xDEADBEEF, followed by `done`.
- After DONE, keep `in_valid`=1 with random data for 10 cycles -> `in_ready`=0, no `mem_we`, `done` stays 1.
